misr_signature_ctrl: RTL and testbench
======================================

// Module: misr_signature_ctrl
// PURPOSE
//  Sequencer for the 32-bit CRC/MISR signature register on the CRC_OUT_2 path.
//  Seeds the MISR, compacts a programmed number of data words with a valid/ready handshake,
//  then compares the result against a golden signature and reports pass/fail.
//  Sits between the BIST/test controller (cfg, start) and the response datapath (data_in).
// PARAMETERS
//  WIDTH    32            MISR and data width
//  POLY     32'h00010409  feedback taps (bits 0,3,10,16), XORed in when signature[WIDTH-1]=1
//  CNT_W    16            width of length and beat counters
//  TIMEOUT  1024          idle-cycle limit in COMPACT (used only with MISR_TIMEOUT_EN)
// PORTS
//  CK          in   1      clock, rising edge
//  RESET       in   1      asynchronous reset, active low
//  start       in   1      begin a run; sampled only in IDLE
//  cfg_len     in   CNT_W  number of words to compact; latched on start
//  cfg_seed    in   WIDTH  initial MISR value; loaded on start
//  cfg_golden  in   WIDTH  expected signature; latched on start
//  data_valid  in   1      data_in holds a word
//  data_in     in   WIDTH  word to compact
//  data_ready  out  1      block accepts a word (high only in COMPACT)
//  busy        out  1      high in COMPACT, CHECK and DONE
//  done        out  1      one-cycle pulse at end of run
//  pass        out  1      result of last run; held until the next accepted start
//  timeout     out  1      last run aborted on idle limit; held until next accepted start
//  signature   out  WIDTH  current MISR contents
// BEHAVIOUR
//  - Reset (RESET=0, async): state IDLE; signature, pass, timeout, done, busy, data_ready,
//    counters all 0. Reset mid-run aborts immediately; no done pulse is issued.
//  - FSM states: IDLE -> COMPACT -> CHECK -> DONE -> IDLE.
//  - IDLE: start=1 loads signature<=cfg_seed, latches len/golden, clears pass, timeout, beat_cnt.
//    Next state is COMPACT, or CHECK directly if cfg_len==0.
//  - start outside IDLE, including in DONE, is ignored.
//  - COMPACT: data_ready=1. A beat is data_valid & data_ready. On each beat:
//      nxt[0] = sig[W-1] ^ d[0];
//      nxt[i] = sig[i-1] ^ d[i] ^ (POLY[i] & sig[W-1]), for i = 1..W-1.
//    beat_cnt increments on each beat. On the beat where beat_cnt==len-1, the FSM goes to CHECK.
//    data_valid while not in COMPACT is ignored; no word is consumed.
//  - CHECK, one cycle: pass <= (signature == golden); signature is frozen.
//  - DONE, one cycle: done=1; the FSM then returns to IDLE.
//  - Latency: last beat at edge t -> CHECK in cycle t+1 -> done=1 in cycle t+2.
//    len==0: start at edge t -> done=1 in cycle t+2.
//  - Arithmetic: beat_cnt is CNT_W bits. cfg_len = 2^CNT_W-1 is the maximum; no wrap.
//  - signature stays at its final value after done, until the next start or reset.
//  - All outputs are registered, except data_ready and busy, which decode the state register.
// CONFIGURATION
//  MISR_TIMEOUT_EN defined:
//    - An idle counter runs in COMPACT. It clears on every beat and increments otherwise.
//    - When it reaches TIMEOUT, the FSM goes to DONE, sets timeout=1 and pass=0,
//      and freezes signature.
//  MISR_TIMEOUT_EN undefined: no idle counter; timeout is tied 0; COMPACT waits indefinitely.
// TESTING
//  1. seed=0, len=1, data=32'h00000001, golden=32'h00000001:
//     signature=32'h00000001, done 2 cycles after beat, pass=1.
//  2. seed=32'h80000000, len=1, data=0 -> signature=32'h00010409 (feedback taps).
//     Golden 0 -> pass=0.
//  3. len=0, seed=golden=32'h12345678, start at edge t:
//     done=1 in cycle t+2, pass=1, data_ready never asserted.
//  4. len=4 with data_valid toggling 1,0,1,0...:
//     exactly 4 words consumed, signature equals the software model; start pulses while busy ignored.
//  5. RESET low for 1 cycle after 2 of 4 beats: all outputs 0, no done.
//     A new start then completes normally.
//  6. (MISR_TIMEOUT_EN, TIMEOUT=8) len=2, one beat then data_valid=0:
//     done after 8 idle cycles, timeout=1, pass=0.

Source files
------------

// File: rtl/misr_signature_ctrl.sv
// Seeds a 32-bit MISR, compacts cfg_len words over valid/ready, checks against golden; done 2 cycles after last beat.
// data_ready only in COMPACT (stalls source otherwise). Optional idle limit: `define MISR_TIMEOUT_EN.
module misr_signature_ctrl #(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  POLY    = 32'h00010409,
  parameter int                CNT_W   = 16,
  parameter int                TIMEOUT = 1024
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [WIDTH-1:0] cfg_golden,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_COMPACT, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             beat;
  logic             idle_hit;
  logic [WIDTH-1:0] misr_nxt;

  assign data_ready = (state_q == S_COMPACT);
  assign busy       = (state_q != S_IDLE);
  assign beat       = data_valid & data_ready;

  always_comb begin
    misr_nxt    = '0;
    misr_nxt[0] = sig_q[WIDTH-1] ^ data_in[0];
    for (int i = 1; i < WIDTH; i++) begin
      misr_nxt[i] = sig_q[i-1] ^ data_in[i] ^ (POLY[i] & sig_q[WIDTH-1]);
    end
  end

`ifdef MISR_TIMEOUT_EN
  localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Counts consecutive beat-less COMPACT cycles; any beat or leaving COMPACT restarts it.
  always_comb begin
    idle_d = '0;
    if ((state_q == S_COMPACT) && !beat) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  assign idle_hit = (state_q == S_COMPACT) && !beat && (idle_q == IDLE_LAST);

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign idle_hit           = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    golden_d  = golden_q;
    len_d     = len_q;
    beat_d    = beat_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d     = cfg_seed;
          golden_d  = cfg_golden;
          len_d     = cfg_len;
          beat_d    = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = (cfg_len == '0) ? S_CHECK : S_COMPACT;
        end
      end
      S_COMPACT: begin
        if (beat) begin
          sig_d  = misr_nxt;
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == (len_q - CNT_W'(1))) begin
            state_d = S_CHECK;
          end
        end else if (idle_hit) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_CHECK: begin
        pass_d  = (sig_q == golden_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // done is registered, so it is asserted on the edge that enters DONE.
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      sig_q     <= '0;
      golden_q  <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      golden_q  <= golden_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign signature = sig_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_misr_signature_ctrl.sv
// Randomized bench for misr_signature_ctrl against a word-level MISR model (shift/xor arithmetic).
module tb_misr_signature_ctrl;

  localparam logic [31:0] POLY_TB    = 32'h00010409;
  localparam int          TIMEOUT_TB = 8;

  logic        CK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_seed = '0;
  logic [31:0] cfg_golden = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] signature;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words[$];

  always #5 CK = ~CK;

  misr_signature_ctrl #(
    .WIDTH  (32),
    .POLY   (POLY_TB),
    .CNT_W  (16),
    .TIMEOUT(TIMEOUT_TB)
  ) dut (
    .CK        (CK),
    .RESET     (RESET),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_seed  (cfg_seed),
    .cfg_golden(cfg_golden),
    .data_valid(data_valid),
    .data_in   (data_in),
    .data_ready(data_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .signature (signature)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Multiply-by-x in GF(2)[x] mod the tap polynomial, then add the data word.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] d);
    return (s << 1) ^ d ^ (s[31] ? POLY_TB : 32'h0);
  endfunction

  function automatic logic [31:0] model_run(input logic [31:0] seed, input int n);
    logic [31:0] s = seed;
    for (int k = 0; k < n; k++) s = model_step(s, words[k]);
    return s;
  endfunction

  // Entered and left at posedge+1. Words come from the words queue.
  task automatic run_case(input string tag, input logic [31:0] seed, input int len,
                          input logic [31:0] golden, input bit toggle, input int abort_at);
    logic [31:0] exp_sig;
    int          beats = 0;
    int          cyc   = 0;
    int          zeros = 0;
    bit          v;
    logic [31:0] d;
    exp_sig    = seed;
    cfg_seed   = seed;
    cfg_len    = 16'(len);
    cfg_golden = golden;
    start      = 1'b1;
    @(negedge CK);
    chk({tag, "/idle_busy"}, 32'(busy), 0);
    chk({tag, "/idle_rdy"}, 32'(data_ready), 0);
    @(posedge CK); #1;
    start = 1'b0;
    chk({tag, "/seed"}, signature, seed);
    chk({tag, "/pass_clr"}, 32'(pass), 0);
    while (beats < len) begin
      if (cyc > 400) begin
        chk({tag, "/beat_budget"}, 32'(beats), 32'(len));
        break;
      end
      if (toggle) v = (cyc % 2 == 0);
      else        v = (zeros >= 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
      zeros      = v ? 0 : zeros + 1;
      d          = words[beats];
      data_valid = v;
      data_in    = v ? d : $urandom;
      start      = ($urandom_range(0, 3) == 0);
      cfg_seed   = $urandom;
      cfg_len    = 16'($urandom);
      @(negedge CK);
      chk({tag, "/rdy"}, 32'(data_ready), 1);
      chk({tag, "/busy"}, 32'(busy), 1);
      chk({tag, "/no_done"}, 32'(done), 0);
      @(posedge CK); #1;
      if (v) begin
        exp_sig = model_step(exp_sig, d);
        beats++;
      end
      cyc++;
      if (abort_at >= 0 && beats == abort_at) begin
        data_valid = 1'b0;
        start      = 1'b0;
        RESET      = 1'b0;
        #1;
        chk({tag, "/rst_sig"}, signature, 0);
        chk({tag, "/rst_pass"}, 32'(pass), 0);
        chk({tag, "/rst_to"}, 32'(timeout), 0);
        chk({tag, "/rst_done"}, 32'(done), 0);
        chk({tag, "/rst_busy"}, 32'(busy), 0);
        chk({tag, "/rst_rdy"}, 32'(data_ready), 0);
        @(posedge CK); #1;
        RESET = 1'b1;
        repeat (4) begin
          @(negedge CK);
          chk({tag, "/post_rst_done"}, 32'(done), 0);
          chk({tag, "/post_rst_busy"}, 32'(busy), 0);
        end
        @(posedge CK); #1;
        return;
      end
    end
    data_valid = 1'b0;
    start      = 1'b0;
    @(negedge CK);
    chk({tag, "/chk_rdy"}, 32'(data_ready), 0);
    chk({tag, "/chk_busy"}, 32'(busy), 1);
    chk({tag, "/chk_done"}, 32'(done), 0);
    chk({tag, "/chk_sig"}, signature, exp_sig);
    @(posedge CK); #1;
    start    = 1'b1;
    cfg_len  = 16'd0;
    cfg_seed = $urandom;
    @(negedge CK);
    chk({tag, "/done"}, 32'(done), 1);
    chk({tag, "/pass"}, 32'(pass), 32'(exp_sig == golden));
    chk({tag, "/timeout"}, 32'(timeout), 0);
    chk({tag, "/sig"}, signature, exp_sig);
    @(posedge CK); #1;
    start = 1'b0;
    @(negedge CK);
    chk({tag, "/done_pulse"}, 32'(done), 0);
    chk({tag, "/back_idle"}, 32'(busy), 0);
    chk({tag, "/sig_hold"}, signature, exp_sig);
    chk({tag, "/pass_hold"}, 32'(pass), 32'(exp_sig == golden));
    @(posedge CK); #1;
  endtask

`ifdef MISR_TIMEOUT_EN
  task automatic timeout_case();
    logic [31:0] d;
    int          k = 0;
    d          = $urandom;
    cfg_seed   = 32'hCAFE0001;
    cfg_len    = 16'd2;
    cfg_golden = model_step(32'hCAFE0001, d);
    start      = 1'b1;
    @(posedge CK); #1;
    start      = 1'b0;
    data_valid = 1'b1;
    data_in    = d;
    @(posedge CK); #1;
    data_valid = 1'b0;
    while (k < 50) begin
      @(negedge CK);
      if (done) break;
      k++;
      @(posedge CK); #1;
    end
    chk("to/idle_cycles", 32'(k), TIMEOUT_TB);
    chk("to/done", 32'(done), 1);
    chk("to/timeout", 32'(timeout), 1);
    chk("to/pass", 32'(pass), 0);
    chk("to/sig", signature, model_step(32'hCAFE0001, d));
    @(posedge CK); #1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fin;
    int          len;
    RESET = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk("reset/sig", signature, 0);
    chk("reset/pass", 32'(pass), 0);
    chk("reset/timeout", 32'(timeout), 0);
    chk("reset/done", 32'(done), 0);
    chk("reset/busy", 32'(busy), 0);
    chk("reset/rdy", 32'(data_ready), 0);
    RESET = 1'b1;
    @(posedge CK); #1;

    words = {32'h00000001};
    run_case("t1", 32'h0, 1, 32'h00000001, 1'b0, -1);
    chk("t1/abs_sig", signature, 32'h00000001);
    chk("t1/abs_pass", 32'(pass), 1);

    words = {32'h00000000};
    run_case("t2", 32'h80000000, 1, 32'h0, 1'b0, -1);
    chk("t2/abs_sig", signature, 32'h00010409);
    chk("t2/abs_pass", 32'(pass), 0);

    words.delete();
    run_case("t3", 32'h12345678, 0, 32'h12345678, 1'b0, -1);
    chk("t3/abs_pass", 32'(pass), 1);

    words.delete();
    repeat (4) words.push_back($urandom);
    run_case("t4", 32'h0BADF00D, 4, model_run(32'h0BADF00D, 4), 1'b1, -1);
    chk("t4/abs_pass", 32'(pass), 1);

    run_case("t5a", 32'h55AA55AA, 4, 32'h0, 1'b0, 2);
    words.delete();
    repeat (4) words.push_back($urandom);
    run_case("t5b", 32'h55AA55AA, 4, model_run(32'h55AA55AA, 4), 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(0, 9);
      words.delete();
      repeat (len) words.push_back($urandom);
      fin = $urandom;
      run_case("rnd", fin, len,
               ($urandom_range(0, 1) == 1) ? model_run(fin, len) : model_run(fin, len) ^ 32'h1,
               1'b0, -1);
    end

`ifdef MISR_TIMEOUT_EN
    timeout_case();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
